mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multicycle MIPS controller: Moore FSM sequencing one shared ALU/memory datapath over 3-5 cycles per
//  instruction (lw, sw, R-type, addi, beq, j). Replaces the single-cycle opcode decoder when the core
//  runs multicycle. Adds a memory-ready stall handshake, an illegal-opcode flag and a retired-instruction counter.
// PARAMETERS
//  CNT_W   32  width of retired-instruction counter (wraps modulo 2^CNT_W)
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  reset        in   1      synchronous, active-high
//  op           in   6      opcode field of instruction register
//  zero         in   1      ALU zero flag (beq compare)
//  mem_ready    in   1      memory completes access this cycle
//  pc_en        out  1      PC load = pc_write | (branch & zero)
//  pc_write     out  1      unconditional PC write
//  branch       out  1      conditional PC write
//  iord         out  1      0: address=PC, 1: address=ALUOut
//  mem_write    out  1      memory write strobe
//  ir_write     out  1      instruction register load
//  reg_dst      out  1      1: rd, 0: rt
//  mem_to_reg   out  1      1: write-back from memory data
//  reg_write    out  1      register file write strobe
//  alu_src_a    out  1      0: PC, 1: register A
//  alu_src_b    out  2      00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  alu_op       out  2      00 add, 01 sub, 10 funct-decoded
//  pc_src       out  2      00 ALU result, 01 ALUOut, 10 jump target
//  instr_done   out  1      one-cycle pulse in final state of each instruction
//  illegal_op   out  1      one-cycle pulse: unsupported opcode in DECODE
//  retired      out  CNT_W  count of instr_done pulses since reset
// BEHAVIOUR
//  Reset: state<=FETCH, retired<=0; while reset=1 pc_en/pc_write/ir_write/mem_write/reg_write/
//   instr_done/illegal_op forced 0. Reset mid-instruction aborts it; no strobe issues in that cycle.
//  Outputs: combinational decode of state (plus mem_ready gating, op for illegal_op); unlisted = 0.
//  FETCH    : iord=0 src_a=0 src_b=01 alu_op=00 pc_src=00; ir_write=pc_write=mem_ready;
//             mem_ready=0 -> hold FETCH, no strobes; mem_ready=1 -> DECODE.
//  DECODE   : src_a=0 src_b=11 alu_op=00 (branch target to ALUOut). Next on op:
//             100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX,
//             000010 -> JUMP, other -> FETCH with illegal_op=1 (no instr_done, retired unchanged).
//  MEMADR   : src_a=1 src_b=10 alu_op=00; lw -> MEMREAD, sw -> MEMWRITE.
//  MEMREAD  : iord=1; hold until mem_ready=1 -> MEMWB.
//  MEMWB    : reg_dst=0 mem_to_reg=1 reg_write=1 instr_done=1 -> FETCH.
//  MEMWRITE : iord=1 mem_write=1 (held during stall); mem_ready=1 -> FETCH with instr_done=1.
//  EXECUTE  : src_a=1 src_b=00 alu_op=10 -> ALUWB.
//  ALUWB    : reg_dst=1 mem_to_reg=0 reg_write=1 instr_done=1 -> FETCH.
//  BRANCH   : src_a=1 src_b=00 alu_op=01 pc_src=01 branch=1 instr_done=1 -> FETCH.
//  ADDIEX   : src_a=1 src_b=10 alu_op=00 -> ADDIWB.
//  ADDIWB   : reg_dst=0 mem_to_reg=0 reg_write=1 instr_done=1 -> FETCH.
//  JUMP     : pc_src=10 pc_write=1 instr_done=1 -> FETCH.
//  Latency, mem_ready tied 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles; each stall cycle adds 1.
//  op is sampled in DECODE and MEMADR only; changes elsewhere have no effect.
//  Unreachable state encodings -> FETCH next cycle, all strobes 0.
//  retired increments on every cycle with instr_done=1; all-ones wraps to 0.
// STRUCTURE
//  Package mc_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), state enum
//   (4-bit), ALU_OP_* and SRC_B_* / PC_SRC_* encodings; shared with datapath and ALU decoder.
//  Sub-module mc_state_outputs: pure combinational state->control-word decode; FSM next-state,
//   stall gating and counter remain in mc_control_fsm.
// TESTING
//  reset 1 cycle, mem_ready=1, op=100011 -> states F,D,MA,MR,MWB; reg_write=1 mem_to_reg=1 in cycle 5; retired=1.
//  op=000100, zero=1 then zero=0 -> pc_en=1 in BRANCH cycle 3 of first, pc_en=0 in second; retired=2.
//  op=101011, mem_ready low 3 cycles in MEMWRITE -> mem_write held 4 cycles, instr_done once, total 7 cycles.
//  op=111111 -> illegal_op=1 in DECODE for one cycle, back to FETCH, no strobes, retired unchanged.
//  reset asserted in ALUWB -> reg_write=0 that cycle, FETCH next, retired=0.
//  preload retired near wrap (CNT_W=4), run 16 j instructions -> retired wraps 15->0, 3 cycles each.

Source files
------------

// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle MIPS control path: opcode constants,
// the controller state encoding, ALU / mux select encodings and the packed
// control word produced by the state decoder. Also used by the datapath and
// the ALU decoder so that select encodings stay consistent.
// -----------------------------------------------------------------------------
package mc_pkg;

  // Supported opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation select
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // Ungated control word for one state; mem_ready / reset gating is applied later
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_state_outputs.sv
// -----------------------------------------------------------------------------
// mc_state_outputs
// Pure combinational decode of the controller state into the raw control word.
// Strobes that depend on memory handshake or reset are emitted unconditionally
// here and gated in mc_control_fsm.
// Ports:
//   state_i  in   4   current controller state
//   ctrl_o   out      raw control word for that state
// -----------------------------------------------------------------------------
module mc_state_outputs
  import mc_pkg::*;
(
  input  logic [3:0] state_i,
  output ctrl_t      ctrl_o
);

  // State to control-word table; unlisted fields stay zero, unreachable codes give all zero
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.alu_src_b = SRC_B_FOUR;
        ctrl_o.alu_op    = ALU_OP_ADD;
        ctrl_o.pc_src    = PC_SRC_ALU;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
      end
      S_DECODE: begin
        // Precompute branch target into ALUOut
        ctrl_o.alu_src_b = SRC_B_IMM_SH2;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRC_B_IMM;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      S_MEMREAD: begin
        ctrl_o.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_o.iord       = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRC_B_REG;
        ctrl_o.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRC_B_REG;
        ctrl_o.alu_op     = ALU_OP_SUB;
        ctrl_o.pc_src     = PC_SRC_ALUOUT;
        ctrl_o.branch     = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRC_B_IMM;
        ctrl_o.alu_op    = ALU_OP_ADD;
      end
      S_ADDIWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_src     = PC_SRC_JUMP;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Multicycle MIPS controller. Moore FSM sequencing a shared ALU/memory datapath
// through 3-5 cycles per instruction, with a memory-ready stall handshake, an
// illegal-opcode pulse and a retired-instruction counter.
// Ports:
//   clk, reset (sync, active-high); op, zero, mem_ready inputs
//   pc_en, pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg,
//   reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0]  datapath controls
//   instr_done, illegal_op  per-instruction pulses
//   retired[CNT_W-1:0]      instr_done count since reset, wraps
// -----------------------------------------------------------------------------
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             pc_write,
  output logic             branch,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            raw_s;
  logic             fetch_stall_s, write_stall_s, live_s;

  mc_state_outputs u_state_outputs (
    .state_i (state_q),
    .ctrl_o  (raw_s)
  );

  // Next-state selection; op only matters in DECODE and MEMADR
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEX:   state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Stall and reset gating of strobes; mux selects pass straight through
  always_comb begin
    fetch_stall_s = (state_q == S_FETCH) & ~mem_ready;
    write_stall_s = (state_q == S_MEMWRITE) & ~mem_ready;
    live_s        = ~reset;

    pc_write   = raw_s.pc_write & ~fetch_stall_s & live_s;
    ir_write   = raw_s.ir_write & ~fetch_stall_s & live_s;
    mem_write  = raw_s.mem_write & live_s;
    reg_write  = raw_s.reg_write & live_s;
    instr_done = raw_s.instr_done & ~write_stall_s & live_s;
    illegal_op = (state_q == S_DECODE) & ~is_legal_op(op) & live_s;
    pc_en      = (pc_write | (raw_s.branch & zero)) & live_s;

    branch     = raw_s.branch;
    iord       = raw_s.iord;
    reg_dst    = raw_s.reg_dst;
    mem_to_reg = raw_s.mem_to_reg;
    alu_src_a  = raw_s.alu_src_a;
    alu_src_b  = raw_s.alu_src_b;
    alu_op     = raw_s.alu_op;
    pc_src     = raw_s.pc_src;
    retired    = retired_q;
  end

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done) begin
        retired_q <= retired_q + CNT_W'(1);
      end else begin
        retired_q <= retired_q;
      end
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
// Scoreboard bench: the stimulus process drives one cycle at a time and pushes
// the expected control outputs and retired count for that cycle; a separate
// monitor pops and compares on the falling edge. The counter is built 4 bits
// wide so wrap-around is reached quickly.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, zero, mem_ready;
  logic [5:0]    op;
  logic          pc_en, pc_write, branch, iord, mem_write, ir_write;
  logic          reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_src;
  logic          instr_done, illegal_op;
  logic [CW-1:0] retired;

  mc_control_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_write(pc_write), .branch(branch), .iord(iord),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .instr_done(instr_done), .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clk = ~clk;

  // Instruction phases as described by the instruction-level behaviour
  typedef enum int {PF, PD, PDI, PMA, PMR, PMWB, PMW, PEX, PAWB, PBR, PAX, PIWB, PJ} ph_e;

  typedef struct {
    logic [17:0] w;
    int          ret;
    ph_e         ph;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_ret = 0;

  // Expected outputs for a phase: {pc_en,pc_write,branch,iord,mem_write,ir_write,
  // reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op,pc_src,instr_done,illegal_op}
  function automatic logic [17:0] model(ph_e ph, bit mr, bit z, bit rst);
    logic pcw = 1'b0, br = 1'b0, io = 1'b0, mw = 1'b0, irw = 1'b0, rd = 1'b0;
    logic m2r = 1'b0, rw = 1'b0, sa = 1'b0, done = 1'b0, ill = 1'b0, pce;
    logic [1:0] sb = 2'b00, ao = 2'b00, ps = 2'b00;
    case (ph)
      PF:   begin sb = 2'b01; irw = mr; pcw = mr; end
      PD:   begin sb = 2'b11; end
      PDI:  begin sb = 2'b11; ill = 1'b1; end
      PMA:  begin sa = 1'b1; sb = 2'b10; end
      PMR:  begin io = 1'b1; end
      PMWB: begin m2r = 1'b1; rw = 1'b1; done = 1'b1; end
      PMW:  begin io = 1'b1; mw = 1'b1; done = mr; end
      PEX:  begin sa = 1'b1; ao = 2'b10; end
      PAWB: begin rd = 1'b1; rw = 1'b1; done = 1'b1; end
      PBR:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; done = 1'b1; end
      PAX:  begin sa = 1'b1; sb = 2'b10; end
      PIWB: begin rw = 1'b1; done = 1'b1; end
      PJ:   begin ps = 2'b10; pcw = 1'b1; done = 1'b1; end
      default: begin end
    endcase
    if (rst) begin
      pcw = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; done = 1'b0; ill = 1'b0;
    end
    pce = rst ? 1'b0 : (pcw | (br & z));
    return {pce, pcw, br, io, mw, irw, rd, m2r, rw, sa, sb, ao, ps, done, ill};
  endfunction

  function automatic bit rb();
    return 1'($urandom());
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom());
  endfunction

  // Drive one cycle of inputs and push what the outputs must be during it
  task automatic cycle(ph_e ph, logic [5:0] op_v, bit mr, bit z, bit rst);
    exp_t e;
    @(posedge clk);
    #1;
    op = op_v; mem_ready = mr; zero = z; reset = rst;
    e.w = model(ph, mr, z, rst);
    e.ret = model_ret;
    e.ph = ph;
    exp_q.push_back(e);
    if (rst) model_ret = 0;
    else if (e.w[1]) model_ret = (model_ret + 1) % 16;
  endtask

  // One instruction: fst fetch stalls, mst memory stalls, z for beq, rst_wb resets in ALUWB
  task automatic run_instr(logic [5:0] opc, int fst, int mst, bit z, bit rst_wb);
    repeat (fst) cycle(PF, rop(), 1'b0, rb(), 1'b0);
    cycle(PF, rop(), 1'b1, rb(), 1'b0);
    case (opc)
      6'b100011: begin
        cycle(PD, opc, rb(), rb(), 1'b0);
        cycle(PMA, opc, rb(), rb(), 1'b0);
        repeat (mst) cycle(PMR, rop(), 1'b0, rb(), 1'b0);
        cycle(PMR, rop(), 1'b1, rb(), 1'b0);
        cycle(PMWB, rop(), rb(), rb(), 1'b0);
      end
      6'b101011: begin
        cycle(PD, opc, rb(), rb(), 1'b0);
        cycle(PMA, opc, rb(), rb(), 1'b0);
        repeat (mst) cycle(PMW, rop(), 1'b0, rb(), 1'b0);
        cycle(PMW, rop(), 1'b1, rb(), 1'b0);
      end
      6'b000000: begin
        cycle(PD, opc, rb(), rb(), 1'b0);
        cycle(PEX, rop(), rb(), rb(), 1'b0);
        cycle(PAWB, rop(), rb(), rb(), rst_wb);
      end
      6'b000100: begin
        cycle(PD, opc, rb(), rb(), 1'b0);
        cycle(PBR, rop(), rb(), z, 1'b0);
      end
      6'b001000: begin
        cycle(PD, opc, rb(), rb(), 1'b0);
        cycle(PAX, rop(), rb(), rb(), 1'b0);
        cycle(PIWB, rop(), rb(), rb(), 1'b0);
      end
      6'b000010: begin
        cycle(PD, opc, rb(), rb(), 1'b0);
        cycle(PJ, rop(), rb(), rb(), 1'b0);
      end
      default: begin
        cycle(PDI, opc, rb(), rb(), 1'b0);
      end
    endcase
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  initial begin
    exp_t        e;
    logic [17:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {pc_en, pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op};
        checks++;
        if (got !== e.w) begin
          failures++;
          $display("FAIL ctrl[%s] t=%0t got=%b exp=%b", e.ph.name(), $time, got, e.w);
        end
        checks++;
        if (retired !== CW'(e.ret)) begin
          failures++;
          $display("FAIL retired[%s] t=%0t got=%0d exp=%0d", e.ph.name(), $time, retired, e.ret);
        end
      end
    end
  end

  logic [5:0] pool [7];

  initial begin
    pool[0] = 6'b100011; pool[1] = 6'b101011; pool[2] = 6'b000000; pool[3] = 6'b000100;
    pool[4] = 6'b001000; pool[5] = 6'b000010; pool[6] = 6'b111111;
    reset = 1'b1; op = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    cycle(PF, rop(), rb(), rb(), 1'b1);

    run_instr(6'b100011, 0, 0, 1'b0, 1'b0);   // lw, no stalls
    run_instr(6'b000100, 0, 0, 1'b1, 1'b0);   // beq taken
    run_instr(6'b000100, 0, 0, 1'b0, 1'b0);   // beq not taken
    run_instr(6'b101011, 0, 3, 1'b0, 1'b0);   // sw with 3 write stalls
    run_instr(6'b111111, 0, 0, 1'b0, 1'b0);   // illegal opcode
    run_instr(6'b001000, 1, 0, 1'b0, 1'b0);   // addi after fetch stall
    run_instr(6'b000000, 0, 0, 1'b0, 1'b1);   // R-type, reset in ALUWB
    run_instr(6'b100011, 2, 2, 1'b0, 1'b0);   // lw with fetch and read stalls

    for (int i = 0; i < 40; i++) begin
      logic [5:0] o;
      o = (($urandom() % 8) == 0) ? rop() : pool[$urandom() % 7];
      run_instr(o, int'($urandom() % 3), int'($urandom() % 3), rb(), 1'b0);
    end

    for (int i = 0; i < 16; i++) run_instr(6'b000010, 0, 0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0 pending entries", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
